seg_595_scan_ctrl: RTL

//  Time-multiplexed scan controller for the 6-digit 7-segment display behind the 74HC595 chain.

---
 rtl/seg595_pkg.sv | 17 +
 rtl/hc595_shifter.sv | 120 ++++++++++++
 rtl/seg_595_scan_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/seg595_pkg.sv
// Shared constants and state encodings for the 74HC595 seven-segment scan controller.
package seg595_pkg;

    localparam int SEL_W  = 6;
    localparam int SEG_W  = 8;
    localparam int WORD_W = SEG_W + SEL_W;

    // All segments off (segments are active-low, bit7 = dp)
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } sh_state_e;

endpackage

// File: rtl/hc595_shifter.sv
// Serialises one {seg, sel} word MSB-first onto ds/shcp, then pulses stcp.
// All pins are registered; busy covers the whole shift plus the latch pulse.
module hc595_shifter
    import seg595_pkg::*;
#(
    parameter int SHCP_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] word,
    output logic              ds,
    output logic              shcp,
    output logic              stcp,
    output logic              busy
);

    localparam int PH_W  = (SHCP_DIV > 2) ? $clog2(SHCP_DIV) : 1;
    localparam int BIT_W = $clog2(WORD_W);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(SHCP_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HALF   = PH_W'(SHCP_DIV / 2);
    localparam logic [PH_W-1:0]  PH_LATCH  = PH_W'(SHCP_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_FIRST = BIT_W'(WORD_W - 1);

    sh_state_e         state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d, phase_inc;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              ds_q, ds_d, shcp_q, shcp_d, stcp_q, stcp_d, busy_q, busy_d;

    // State, counters and pin registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            ds_q    <= 1'b0;
            shcp_q  <= 1'b0;
            stcp_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            ds_q    <= ds_d;
            shcp_q  <= shcp_d;
            stcp_q  <= stcp_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: ds changes at bit start, shcp high in the second half of each bit
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        word_d    = word_q;
        ds_d      = ds_q;
        shcp_d    = shcp_q;
        stcp_d    = stcp_q;
        busy_d    = busy_q;
        phase_inc = phase_q + PH_W'(1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    word_d  = word;
                    bit_d   = BIT_FIRST;
                    phase_d = '0;
                    ds_d    = word[WORD_W-1];
                    shcp_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    shcp_d  = 1'b0;
                    if (bit_q == '0) begin
                        state_d = LATCH;
                        ds_d    = 1'b0;
                        stcp_d  = 1'b1;
                    end else begin
                        bit_d  = bit_q - BIT_W'(1);
                        word_d = word_q << 1;
                        ds_d   = word_q[WORD_W-2];
                    end
                end else begin
                    phase_d = phase_inc;
                    shcp_d  = (phase_inc >= PH_HALF);
                end
            end
            LATCH: begin
                if (phase_q == PH_LATCH) begin
                    state_d = IDLE;
                    phase_d = '0;
                    stcp_d  = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    phase_d = phase_inc;
                end
            end
            default: begin
                state_d = IDLE;
                ds_d    = 1'b0;
                shcp_d  = 1'b0;
                stcp_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign ds   = ds_q;
    assign shcp = shcp_q;
    assign stcp = stcp_q;
    assign busy = busy_q;

endmodule

// File: rtl/seg_595_scan_ctrl.sv
// Six-digit scan controller: dwell counter, digit index, double-buffered
// segment patterns and output-enable control in front of the 595 shifter.
module seg_595_scan_ctrl
    import seg595_pkg::*;
#(
    parameter int DIGITS        = 6,
    parameter int CNT_DWELL_MAX = 49_999,
    parameter int SHCP_DIV      = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [8*DIGITS-1:0] seg_in,
    input  logic                upd,
    input  logic                en,
    output logic                ds,
    output logic                shcp,
    output logic                stcp,
    output logic                oe,
    output logic                busy
);

    localparam int CNT_W = $clog2(CNT_DWELL_MAX + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_DWELL_MAX);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [DIGITS-1:0][SEG_W-1:0]      staging_q, staging_d, active_q, active_d;
    logic                              pending_q, pending_d;
    logic                              first_q, busy_prev_q, seen_q, seen_d, oe_q, oe_d;
    logic                              boundary, cnt_wrap, start, done, sh_busy;
    logic [SEL_W-1:0]                  sel;
    logic [WORD_W-1:0]                 word;

    // Scan position, buffers and oe state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            staging_q   <= {DIGITS{SEG_BLANK}};
            active_q    <= {DIGITS{SEG_BLANK}};
            pending_q   <= 1'b0;
            first_q     <= 1'b1;
            busy_prev_q <= 1'b0;
            seen_q      <= 1'b0;
            oe_q        <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            staging_q   <= staging_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            first_q     <= 1'b0;
            busy_prev_q <= sh_busy;
            seen_q      <= seen_d;
            oe_q        <= oe_d;
        end
    end

    // Dwell/digit advance, frame-boundary buffer swap, update capture, oe
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        staging_d = staging_q;
        active_d  = active_q;
        pending_d = pending_q;
        cnt_wrap  = (cnt_q == CNT_LAST);
        boundary  = first_q | (cnt_wrap & (idx_q == IDX_LAST));
        if (cnt_wrap) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Swap first so a coinciding update lands in staging and stays pending
        if (boundary && pending_q) begin
            active_d  = staging_q;
            pending_d = 1'b0;
        end
        if (upd) begin
            staging_d = seg_in;
            pending_d = 1'b1;
        end
        // The first completed latch after reset releases the blanking
        done   = busy_prev_q & ~sh_busy;
        seen_d = seen_q | done;
        oe_d   = seen_d ? ~en : 1'b1;
    end

    assign sel   = SEL_W'(1) << idx_q;
    assign word  = {active_q[idx_q], sel};
    assign start = (cnt_q == '0) & ~sh_busy;

    hc595_shifter #(
        .SHCP_DIV (SHCP_DIV)
    ) u_shifter (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .start (start),
        .word  (word),
        .ds    (ds),
        .shcp  (shcp),
        .stcp  (stcp),
        .busy  (sh_busy)
    );

    assign busy = sh_busy;
    assign oe   = oe_q;

endmodule
